// File: rtl/aes_mask_prng.sv
// Mask-word generator for the protected AES unit: a 64-bit Fibonacci LFSR advanced
// 26 steps per cycle, gated by a warm-up FSM, feeding a 2-entry output FIFO.
module aes_mask_prng #(
    parameter logic [63:0] DEFAULT_SEED  = 64'h0123_4567_89AB_CDEF,
    parameter int unsigned WARMUP_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        seed_valid_i,
    input  logic [63:0] seed_i,
    output logic [25:0] rand_o,
    output logic        rand_valid_o,
    input  logic        rand_ready_i,
    output logic        warm_o
);

    typedef enum logic {WARMUP, RUN} state_e;

    localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYCLES - 1);

    // 26 single steps of x^64+x^63+x^61+x^60+1; bit 0 ends up as the newest bit.
    function automatic logic [63:0] lfsr_adv(input logic [63:0] s);
        logic [63:0] t;
        t = s;
        for (int i = 0; i < 26; i++) begin
            t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
        end
        return t;
    endfunction

    state_e      state_q, state_d;
    logic [63:0] lfsr_q, lfsr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [25:0] head_q, head_d;
    logic [25:0] tail_q, tail_d;
    logic [1:0]  fill_q, fill_d;

    logic [63:0] adv;
    logic [25:0] word;
    logic        pop;
    logic        push;

    assign adv          = lfsr_adv(lfsr_q);
    assign word         = adv[25:0];
    assign rand_valid_o = (fill_q != 2'd0);
    assign rand_o       = head_q;
    assign warm_o       = (state_q == RUN);
    assign pop          = rand_valid_o && rand_ready_i;
    // The LFSR only moves in RUN when its word has somewhere to go.
    assign push         = (state_q == RUN) && ((fill_q != 2'd2) || pop);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        head_d  = head_q;
        tail_d  = tail_q;
        fill_d  = fill_q;

        if (seed_valid_i) begin
            lfsr_d  = (seed_i == 64'd0) ? DEFAULT_SEED : seed_i;
            state_d = WARMUP;
            cnt_d   = 8'd0;
            fill_d  = 2'd0;
        end else begin
            unique case (state_q)
                WARMUP: begin
                    lfsr_d = adv;
                    if (cnt_q == WARM_LAST) begin
                        state_d = RUN;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                RUN: begin
                    if (push) lfsr_d = adv;
                end
                default: state_d = WARMUP;
            endcase

            unique case ({push, pop})
                2'b10: begin
                    if (fill_q == 2'd0) head_d = word;
                    else                tail_d = word;
                    fill_d = fill_q + 2'd1;
                end
                2'b01: begin
                    if (fill_q == 2'd2) head_d = tail_q;
                    fill_d = fill_q - 2'd1;
                end
                2'b11: begin
                    if (fill_q == 2'd1) begin
                        head_d = word;
                    end else begin
                        head_d = tail_q;
                        tail_d = word;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WARMUP;
            lfsr_q  <= DEFAULT_SEED;
            cnt_q   <= 8'd0;
            head_q  <= 26'd0;
            tail_q  <= 26'd0;
            fill_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            fill_q  <= fill_d;
        end
    end

endmodule

// File: tb/tb_aes_mask_prng.sv
// Directed bench for aes_mask_prng: warm-up latency, streaming, back-pressure,
// reseed (zero seed and mid-warm-up) and asynchronous reset.
module tb_aes_mask_prng;

    logic        clk;
    logic        rst_n;
    logic        seed_valid;
    logic [63:0] seed;
    logic [25:0] rand_w;
    logic        rand_valid;
    logic        rand_ready;
    logic        warm;

    int checks = 0;
    int errors = 0;

    logic [25:0] defw  [1:200];
    logic [25:0] deadw [1:40];

    aes_mask_prng dut (
        .clk_i        (clk),
        .rst_n        (rst_n),
        .seed_valid_i (seed_valid),
        .seed_i       (seed),
        .rand_o       (rand_w),
        .rand_valid_o (rand_valid),
        .rand_ready_i (rand_ready),
        .warm_o       (warm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: feedback is the parity of taps 63,62,60,59.
    function automatic logic [63:0] ref_adv(input logic [63:0] s);
        logic [63:0] t;
        t = s;
        for (int k = 0; k < 26; k++) t = (t << 1) | 64'(^(t & 64'hD800_0000_0000_0000));
        return t;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts just before edge 1 of a warm-up with rand_ready low; ends after edge 18.
    task automatic warmup_seq(input string tag);
        for (int e = 1; e <= 16; e++) begin
            tick();
            chk({tag, "_valid_low"}, 64'(rand_valid), 64'd0);
            chk({tag, "_warm"}, 64'(warm), 64'(e == 16));
        end
        tick();
        chk({tag, "_valid_e17"}, 64'(rand_valid), 64'd1);
        chk({tag, "_word17"}, 64'(rand_w), 64'(defw[17]));
        tick();
        chk({tag, "_valid_e18"}, 64'(rand_valid), 64'd1);
        chk({tag, "_hold17"}, 64'(rand_w), 64'(defw[17]));
    endtask

    initial begin
        logic [63:0] s;
        int n;
        logic [2:0] pat [0:4];

        s = 64'h0123_4567_89AB_CDEF;
        for (int k = 1; k <= 200; k++) begin s = ref_adv(s); defw[k] = s[25:0]; end
        s = 64'hDEAD_BEEF_CAFE_F00D;
        for (int k = 1; k <= 40; k++) begin s = ref_adv(s); deadw[k] = s[25:0]; end

        rst_n = 1'b0; seed_valid = 1'b0; seed = 64'd0; rand_ready = 1'b0;
        #2;
        chk("rst_valid", 64'(rand_valid), 64'd0);
        chk("rst_word", 64'(rand_w), 64'd0);
        chk("rst_warm", 64'(warm), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset release, no consumer: buffer fills with words 17,18 and freezes.
        warmup_seq("s1");
        tick();
        chk("s1_frozen", 64'(rand_w), 64'(defw[17]));

        // Continuous streaming: words 17..116 with no gaps.
        rand_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            chk("s2_valid", 64'(rand_valid), 64'd1);
            chk("s2_word", 64'(rand_w), 64'(defw[17 + i]));
            tick();
        end
        rand_ready = 1'b0;
        tick();
        chk("s2_stop_head", 64'(rand_w), 64'(defw[117]));

        // Back-pressure pattern 1,0,1,1,0 on a full buffer.
        pat[0] = 3'd1; pat[1] = 3'd0; pat[2] = 3'd1; pat[3] = 3'd1; pat[4] = 3'd0;
        n = 117;
        for (int i = 0; i < 5; i++) begin
            rand_ready = pat[i][0];
            chk("s3_valid", 64'(rand_valid), 64'd1);
            chk("s3_word", 64'(rand_w), 64'(defw[n]));
            tick();
            if (pat[i][0]) n++;
        end
        chk("s3_after", 64'(rand_w), 64'(defw[120]));

        // Zero-seed reseed while popping: old word delivered, then DEFAULT_SEED stream.
        rand_ready = 1'b1; seed_valid = 1'b1; seed = 64'd0;
        chk("s4_old_word", 64'(rand_w), 64'(defw[120]));
        tick();
        seed_valid = 1'b0;
        chk("s4_flush_valid", 64'(rand_valid), 64'd0);
        chk("s4_flush_warm", 64'(warm), 64'd0);
        for (int e = 1; e <= 16; e++) begin
            tick();
            chk("s4_valid_low", 64'(rand_valid), 64'(0));
            if (e == 16) chk("s4_warm", 64'(warm), 64'd1);
        end
        tick();
        chk("s4_valid_e17", 64'(rand_valid), 64'd1);
        chk("s4_word17", 64'(rand_w), 64'(defw[17]));
        for (int i = 18; i <= 22; i++) begin
            tick();
            chk("s4_valid_stream", 64'(rand_valid), 64'd1);
            chk("s4_stream", 64'(rand_w), 64'(defw[i]));
        end

        // Reseed mid-warm-up (counter 9) restarts the count.
        rand_ready = 1'b0; seed_valid = 1'b1; seed = 64'd0;
        tick();
        seed_valid = 1'b0;
        for (int e = 0; e < 9; e++) tick();
        seed_valid = 1'b1; seed = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        seed_valid = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            chk("s5_valid_low", 64'(rand_valid), 64'd0);
            if (e == 15) chk("s5_warm_low", 64'(warm), 64'd0);
        end
        tick();
        chk("s5_valid_e17", 64'(rand_valid), 64'd1);
        chk("s5_word17", 64'(rand_w), 64'(deadw[17]));
        rand_ready = 1'b1;
        tick();
        chk("s5_word18", 64'(rand_w), 64'(deadw[18]));
        tick();
        chk("s5_word19", 64'(rand_w), 64'(deadw[19]));

        // Async reset mid-burst takes effect before the next edge.
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_valid", 64'(rand_valid), 64'd0);
        chk("s6_warm", 64'(warm), 64'd0);
        chk("s6_word", 64'(rand_w), 64'd0);
        rand_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        warmup_seq("s6");
        rand_ready = 1'b1;
        tick();
        chk("s6_word18", 64'(rand_w), 64'(defw[18]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
